// File: rtl/shiftreg_ctrl_pkg.sv
// shiftreg_ctrl_pkg: shared state encoding, default sizes and rotate-direction codes.
package shiftreg_ctrl_pkg;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_COUNT_WIDTH = 4;
  localparam logic ROT_RIGHT = 1'b0;
  localparam logic ROT_LEFT = 1'b1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/ring_register_datapath.sv
// ring_register_datapath: ring register with preset and one-step rotation.
// The complement output is registered alongside so both come straight from flops.
module ring_register_datapath
  import shiftreg_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             shift_en,
  input  logic             dir,
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_
);
  logic [WIDTH-1:0] ring_d;
  always_comb
    ring_d = load ? pattern
           : shift_en ? ((dir == ROT_LEFT) ? {signal_q[WIDTH-2:0], signal_q[WIDTH-1]}
                                           : {signal_q[0], signal_q[WIDTH-1:1]})
           : signal_q;
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      signal_q  <= '0;
      signal_q_ <= '1;
    end else begin
      signal_q  <= ring_d;
      signal_q_ <= ~ring_d;
    end
  end
endmodule

// File: rtl/shiftregister_rotate_controller.sv
// shiftregister_rotate_controller: presets a ring register, rotates it a programmed number of steps with hold.
// Define ROTATE_DIR_EN to add the dir input (0 = right, 1 = left), sampled on every shift edge.
module shiftregister_rotate_controller
  import shiftreg_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clockpulse,
  input  logic                   clear,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [COUNT_WIDTH-1:0] steps,
  input  logic                   hold,
`ifdef ROTATE_DIR_EN
  input  logic                   dir,
`endif
  output logic [WIDTH-1:0]       signal_q,
  output logic [WIDTH-1:0]       signal_q_,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] remaining
);
  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   load;
  logic                   shift_en;
  logic                   rot_dir;
`ifdef ROTATE_DIR_EN
  assign rot_dir = dir;
`else
  assign rot_dir = ROT_RIGHT;
`endif
  assign load      = (state_q == IDLE) && start;
  assign shift_en  = (state_q == SHIFT) && !hold && (remaining_q != '0);
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign done      = done_q;
  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          remaining_q <= steps;
          state_q     <= (steps != '0) ? SHIFT : DONE;
          busy_q      <= (steps != '0);
          done_q      <= (steps == '0);
        end
        SHIFT: if (!hold) begin
          remaining_q <= (remaining_q != '0) ? remaining_q - 1'b1 : '0;
          if (remaining_q <= COUNT_WIDTH'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  ring_register_datapath #(.WIDTH(WIDTH)) u_ring (
    .clk      (clockpulse),
    .clear    (clear),
    .load     (load),
    .pattern  (pattern),
    .shift_en (shift_en),
    .dir      (rot_dir),
    .signal_q (signal_q),
    .signal_q_(signal_q_)
  );
endmodule

// File: tb/tb_shiftregister_rotate_controller.sv
// tb_shiftregister_rotate_controller: directed scenario tasks with hand-computed expectations.
module tb_shiftregister_rotate_controller;
  logic       clockpulse;
  logic       clear;
  logic       start;
  logic [4:0] pattern;
  logic [3:0] steps;
  logic       hold;
  logic       dir;
  logic [4:0] signal_q;
  logic [4:0] signal_q_;
  logic       busy;
  logic       done;
  logic [3:0] remaining;
  int tests = 0;
  int failed = 0;

  shiftregister_rotate_controller #(.WIDTH(5), .COUNT_WIDTH(4)) dut (
    .clockpulse(clockpulse),
    .clear     (clear),
    .start     (start),
    .pattern   (pattern),
    .steps     (steps),
    .hold      (hold),
`ifdef ROTATE_DIR_EN
    .dir       (dir),
`endif
    .signal_q  (signal_q),
    .signal_q_ (signal_q_),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial begin
    clockpulse = 1'b0;
    forever #5 clockpulse = ~clockpulse;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clockpulse);
    @(negedge clockpulse);
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b1; pattern = 5'b11111; steps = 4'd3; hold = 1'b0; dir = 1'b0;
    repeat (2) tick;
    tests++;
    if ({signal_q, signal_q_, busy, done, remaining} !== {5'b00000, 5'b11111, 1'b0, 1'b0, 4'd0}) begin
      failed++;
      $display("FAIL reset_during_clear q=%b nq=%b busy=%b done=%b rem=%0d want 00000 11111 0 0 0", signal_q, signal_q_, busy, done, remaining);
    end
    start = 1'b0;
    clear = 1'b0;
    tick;
    tests++;
    if ({signal_q, signal_q_, busy, done, remaining} !== {5'b00000, 5'b11111, 1'b0, 1'b0, 4'd0}) begin
      failed++;
      $display("FAIL reset_idle_after q=%b nq=%b busy=%b done=%b rem=%0d want 00000 11111 0 0 0", signal_q, signal_q_, busy, done, remaining);
    end
  endtask

  task automatic test_basic;
    logic [4:0] exp_q [4] = '{5'b11000, 5'b01100, 5'b00110, 5'b00011};
    pattern = 5'b11000; steps = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({signal_q, signal_q_, busy, done, remaining} !== {exp_q[i], ~exp_q[i], 1'(i < 3), 1'(i == 3), 4'(3 - i)}) begin
        failed++;
        $display("FAIL basic_edge%0d q=%b nq=%b busy=%b done=%b rem=%0d want q=%b busy=%b done=%b rem=%0d",
                 i, signal_q, signal_q_, busy, done, remaining, exp_q[i], i < 3, i == 3, 3 - i);
      end
      if (i < 3) tick;
    end
    tick;
    tests++;
    if ({signal_q, busy, done, remaining} !== {5'b00011, 1'b0, 1'b0, 4'd0}) begin
      failed++;
      $display("FAIL basic_idle q=%b busy=%b done=%b rem=%0d want 00011 0 0 0", signal_q, busy, done, remaining);
    end
    pattern = 5'b11000; steps = 4'd5; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    tests++;
    if ({signal_q, busy, done, remaining} !== {5'b11000, 1'b0, 1'b1, 4'd0}) begin
      failed++;
      $display("FAIL wrap5 q=%b busy=%b done=%b rem=%0d want 11000 0 1 0", signal_q, busy, done, remaining);
    end
    tick;
  endtask

  task automatic test_hold;
    logic [4:0] exp_q [3] = '{5'b00100, 5'b00010, 5'b00001};
    pattern = 5'b10000; steps = 4'd4; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if ({signal_q, busy, done, remaining} !== {5'b01000, 1'b1, 1'b0, 4'd3}) begin
        failed++;
        $display("FAIL hold_cycle%0d q=%b busy=%b done=%b rem=%0d want 01000 1 0 3", i, signal_q, busy, done, remaining);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if ({signal_q, busy, done, remaining} !== {exp_q[i], 1'(i < 2), 1'(i == 2), 4'(2 - i)}) begin
        failed++;
        $display("FAIL hold_resume%0d q=%b busy=%b done=%b rem=%0d want q=%b rem=%0d", i, signal_q, busy, done, remaining, exp_q[i], 2 - i);
      end
    end
    tick;
  endtask

  task automatic test_zero_steps;
    pattern = 5'b10101; steps = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if ({signal_q, busy, done, remaining} !== {5'b10101, 1'b0, 1'b1, 4'd0}) begin
      failed++;
      $display("FAIL zero_done q=%b busy=%b done=%b rem=%0d want 10101 0 1 0", signal_q, busy, done, remaining);
    end
    tick;
    tests++;
    if ({signal_q, busy, done} !== {5'b10101, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL zero_idle q=%b busy=%b done=%b want 10101 0 0", signal_q, busy, done);
    end
  endtask

  task automatic test_max_steps;
    int edges;
    pattern = 5'b10000; steps = 4'd15; start = 1'b1;
    tick;
    start = 1'b0;
    edges = 1;
    tests++;
    if ({signal_q, busy, remaining} !== {5'b10000, 1'b1, 4'd15}) begin
      failed++;
      $display("FAIL max_load q=%b busy=%b rem=%0d want 10000 1 15", signal_q, busy, remaining);
    end
    while (!done && edges < 20) begin
      tick;
      edges++;
    end
    tests++;
    if (edges !== 16 || {signal_q, busy, done, remaining} !== {5'b10000, 1'b0, 1'b1, 4'd0}) begin
      failed++;
      $display("FAIL max_done edges=%0d q=%b busy=%b done=%b rem=%0d want edges=16 10000 0 1 0", edges, signal_q, busy, done, remaining);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_q [5] = '{5'b01010, 5'b00101, 5'b10010, 5'b10010, 5'b01010};
    logic       exp_b [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_r [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd2};
    pattern = 5'b01010; steps = 4'd2; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      tests++;
      if ({signal_q, busy, done, remaining} !== {exp_q[i], exp_b[i], exp_d[i], exp_r[i]}) begin
        failed++;
        $display("FAIL b2b_edge%0d q=%b busy=%b done=%b rem=%0d want %b %b %b %0d",
                 i, signal_q, busy, done, remaining, exp_q[i], exp_b[i], exp_d[i], exp_r[i]);
      end
    end
    start = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_abort;
    bit saw_done;
    pattern = 5'b11000; steps = 4'd4; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    tests++;
    if ({signal_q, remaining} !== {5'b00110, 4'd2}) begin
      failed++;
      $display("FAIL abort_pre q=%b rem=%0d want 00110 2", signal_q, remaining);
    end
    #2 clear = 1'b1;
    #1;
    tests++;
    if ({signal_q, signal_q_, busy, done, remaining} !== {5'b00000, 5'b11111, 1'b0, 1'b0, 4'd0}) begin
      failed++;
      $display("FAIL abort_async q=%b nq=%b busy=%b done=%b rem=%0d want 00000 11111 0 0 0", signal_q, signal_q_, busy, done, remaining);
    end
    @(negedge clockpulse);
    tick;
    clear = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      saw_done |= done;
    end
    tests++;
    if (saw_done !== 1'b0 || signal_q !== 5'b00000) begin
      failed++;
      $display("FAIL abort_no_done saw_done=%b q=%b want 0 00000", saw_done, signal_q);
    end
    pattern = 5'b00001; steps = 4'd1; start = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if ({signal_q, busy, remaining} !== {5'b00001, 1'b1, 4'd1}) begin
      failed++;
      $display("FAIL abort_restart_load q=%b busy=%b rem=%0d want 00001 1 1", signal_q, busy, remaining);
    end
    tick;
    tests++;
    if ({signal_q, busy, done, remaining} !== {5'b10000, 1'b0, 1'b1, 4'd0}) begin
      failed++;
      $display("FAIL abort_restart_done q=%b busy=%b done=%b rem=%0d want 10000 0 1 0", signal_q, busy, done, remaining);
    end
    tick;
  endtask

`ifdef ROTATE_DIR_EN
  task automatic test_dir;
    logic [4:0] exp_q [3] = '{5'b00110, 5'b01100, 5'b00110};
    dir = 1'b1; pattern = 5'b00011; steps = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dir = 1'b0;
      tick;
      tests++;
      if ({signal_q, done, remaining} !== {exp_q[i], 1'(i == 2), 4'(2 - i)}) begin
        failed++;
        $display("FAIL dir_edge%0d q=%b done=%b rem=%0d want %b %b %0d", i, signal_q, done, remaining, exp_q[i], i == 2, 2 - i);
      end
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_zero_steps;
    test_max_steps;
    test_back_to_back;
    test_abort;
`ifdef ROTATE_DIR_EN
    test_dir;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
